// File: rtl/postbox_link.sv
// -----------------------------------------------------------------------------
// postbox_link
//   POST-box link engine. It decodes the Archimedes TESTREQ pulse-train
//   protocol synchronously on refclk. Pulse groups are separated by a low gap
//   of GAP_CYC cycles:
//     1 pulse  = received bit '1'
//     2 pulses = received bit '0'
//     3 pulses = OUTPUT poll
//     4+       = INPUT poll, then data pulses
//   Bytes from the host are collected MSB first and pushed into an RX FIFO.
//   Bytes for the host are taken from a TX FIFO and presented MSB first on
//   TESTAK, one bit per pulse.
//
// Ports
//   refclk      system clock (at least 8x the TESTREQ pulse rate)
//   rst_n       asynchronous active-low reset
//   testreq     raw TESTREQ (LA23), asynchronous to refclk
//   testack     TESTAK = testreq & ack_q; never high without testreq
//   rx_data     head of the RX FIFO
//   rx_valid    RX FIFO not empty
//   rx_ready    pops the RX head when rx_valid & rx_ready
//   tx_data     byte to send to the host
//   tx_valid    TX push request
//   tx_ready    TX FIFO not full; a push happens when tx_valid & tx_ready
//   rx_overrun  sticky: a completed RX byte was dropped because the FIFO was full
//   tx_abort    sticky: an INPUT byte was cut short by a gap
//   link_busy   a pulse group is in progress
// -----------------------------------------------------------------------------

// Small FIFO. Storage is an array with a combinational head read. A push
// becomes visible on head only in the cycle after the push, so there is no
// bypass path. Pushes into a full FIFO and pops from an empty FIFO are ignored.
module postbox_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         refclk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          push_ok;
    logic          pop_ok;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == FULL_CNT);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = mem[rd_ptr_reg];

    always_ff @(posedge refclk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // The depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end
endmodule

module postbox_link #(
    parameter int DATA_W   = 8,
    parameter int RX_DEPTH = 4,
    parameter int TX_DEPTH = 4,
    parameter int GAP_CYC  = 240
) (
    input  logic              refclk,
    input  logic              rst_n,
    input  logic              testreq,
    output logic              testack,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              rx_overrun,
    output logic              tx_abort,
    output logic              link_busy
);
    localparam int GW = $clog2(GAP_CYC + 1);
    localparam int BW = $clog2(DATA_W);
    localparam logic [GW-1:0] GAP_MAX  = GW'(GAP_CYC);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_P1,
        ST_P2,
        ST_P3,
        ST_IPOLL,
        ST_ISEND
    } state_t;

    state_t            state_reg;
    logic              req_meta_reg;
    logic              req_sync_reg;
    logic              req_prev_reg;
    logic [GW-1:0]     gap_cnt_reg;
    logic              ack_q_reg;
    logic [BW-1:0]     bit_i_reg;
    logic [DATA_W-1:0] tx_sh_reg;
    logic [DATA_W-1:0] rx_sh_reg;
    logic [BW-1:0]     rx_cnt_reg;
    logic              rx_overrun_reg;
    logic              tx_abort_reg;

    logic              rise;
    logic              expire;
    logic              rx_bit;
    logic              rx_last;
    logic              rx_push;
    logic [DATA_W-1:0] rx_word;
    logic              rx_empty;
    logic              rx_full;
    logic              tx_pop;
    logic [DATA_W-1:0] tx_head;
    logic              tx_empty;
    logic              tx_full;
    logic [BW-1:0]     bit_dec;

    // Two-flop synchroniser plus edge detector. Everything downstream reacts
    // only to the rising edge of the synchronised request.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            req_meta_reg <= 1'b0;
            req_sync_reg <= 1'b0;
            req_prev_reg <= 1'b0;
        end else begin
            req_meta_reg <= testreq;
            req_sync_reg <= req_meta_reg;
            req_prev_reg <= req_sync_reg;
        end
    end

    assign rise = req_sync_reg & ~req_prev_reg;

    // Gap timer. It saturates at GAP_CYC, so expire fires exactly once per
    // low period. It cannot coincide with rise, because rise needs the
    // request high and expire needs it low.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            gap_cnt_reg <= '0;
        end else if (req_sync_reg) begin
            gap_cnt_reg <= '0;
        end else if (gap_cnt_reg != GAP_MAX) begin
            gap_cnt_reg <= gap_cnt_reg + 1'b1;
        end
    end

    assign expire = ~req_sync_reg & (gap_cnt_reg == GAP_MAX - 1'b1);

    // A 1-pulse group ends in P1 and a 2-pulse group ends in P2.
    assign rx_bit  = (state_reg == ST_P1);
    assign rx_last = (rx_cnt_reg == LAST_BIT);
    assign rx_word = {rx_sh_reg[DATA_W-2:0], rx_bit};
    assign rx_push = expire & ((state_reg == ST_P1) | (state_reg == ST_P2)) & rx_last;

    // The TX head is taken only when the previous poll answered "data ready".
    assign tx_pop  = rise & (state_reg == ST_IPOLL) & ack_q_reg & ~tx_empty;
    assign bit_dec = bit_i_reg - 1'b1;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            ack_q_reg      <= 1'b0;
            bit_i_reg      <= '0;
            tx_sh_reg      <= '0;
            rx_sh_reg      <= '0;
            rx_cnt_reg     <= '0;
            rx_overrun_reg <= 1'b0;
            tx_abort_reg   <= 1'b0;
        end else if (expire) begin
            state_reg <= ST_IDLE;
            ack_q_reg <= 1'b0;
            case (state_reg)
                ST_P1, ST_P2: begin
                    rx_sh_reg  <= rx_word;
                    rx_cnt_reg <= rx_last ? '0 : rx_cnt_reg + 1'b1;
                    if (rx_last && rx_full) rx_overrun_reg <= 1'b1;
                end
                // A bare OUTPUT poll resynchronises the host's bit framing.
                ST_P3: rx_cnt_reg <= '0;
                // With bit_i at 0 the final bit has already been presented,
                // so the byte is complete. Any other position means lost bits.
                ST_ISEND: if (bit_i_reg != '0) tx_abort_reg <= 1'b1;
                default: ;
            endcase
        end else if (rise) begin
            case (state_reg)
                ST_IDLE: begin
                    state_reg <= ST_P1;
                    ack_q_reg <= 1'b1;
                end
                ST_P1: begin
                    state_reg <= ST_P2;
                    ack_q_reg <= 1'b1;
                end
                ST_P2: begin
                    state_reg <= ST_P3;
                    ack_q_reg <= ~rx_full;
                end
                ST_P3: begin
                    state_reg <= ST_IPOLL;
                    ack_q_reg <= ~tx_empty;
                end
                ST_IPOLL: begin
                    if (tx_pop) begin
                        tx_sh_reg <= tx_head;
                        ack_q_reg <= tx_head[DATA_W-1];
                        bit_i_reg <= LAST_BIT;
                        state_reg <= ST_ISEND;
                    end else begin
                        ack_q_reg <= ~tx_empty;
                    end
                end
                ST_ISEND: begin
                    if (bit_i_reg == '0) begin
                        ack_q_reg <= ~tx_empty;
                        state_reg <= ST_IPOLL;
                    end else begin
                        bit_i_reg <= bit_dec;
                        ack_q_reg <= tx_sh_reg[bit_dec];
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    ack_q_reg <= 1'b0;
                end
            endcase
        end
    end

    postbox_fifo #(.W(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .refclk    (refclk),
        .rst_n     (rst_n),
        .push      (rx_push),
        .push_data (rx_word),
        .pop       (rx_ready),
        .head      (rx_data),
        .empty     (rx_empty),
        .full      (rx_full)
    );

    postbox_fifo #(.W(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .refclk    (refclk),
        .rst_n     (rst_n),
        .push      (tx_valid),
        .push_data (tx_data),
        .pop       (tx_pop),
        .head      (tx_head),
        .empty     (tx_empty),
        .full      (tx_full)
    );

    assign testack    = testreq & ack_q_reg;
    assign rx_valid   = ~rx_empty;
    assign tx_ready   = ~tx_full;
    assign rx_overrun = rx_overrun_reg;
    assign tx_abort   = tx_abort_reg;
    assign link_busy  = (state_reg != ST_IDLE);
endmodule

// File: tb/tb_postbox_link.sv
module tb_postbox_link;
    localparam int GAP = 40;
    localparam int DEP = 4;

    logic       refclk = 1'b0;
    logic       rst_n;
    logic       testreq;
    logic       testack;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       rx_overrun;
    logic       tx_abort;
    logic       link_busy;

    int checks = 0;
    int errors = 0;

    postbox_link #(.DATA_W(8), .RX_DEPTH(DEP), .TX_DEPTH(DEP), .GAP_CYC(GAP)) dut (
        .refclk     (refclk),
        .rst_n      (rst_n),
        .testreq    (testreq),
        .testack    (testack),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_overrun (rx_overrun),
        .tx_abort   (tx_abort),
        .link_busy  (link_busy)
    );

    always #5 refclk = ~refclk;

    // Host-side reference model. It tracks FIFO contents as queues, and each
    // group as a count of pulses, with the answer for each pulse taken from
    // the protocol rules.
    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];
    int         m_k;
    bit         m_prev_ack;
    bit         m_sending;
    logic [7:0] m_sbyte;
    int         m_sidx;
    logic [7:0] m_rx_acc;
    int         m_rx_n;
    bit         m_ovr;
    bit         m_abort;

    task automatic model_reset();
        rx_q.delete();
        tx_q.delete();
        m_k = 0; m_prev_ack = 0; m_sending = 0; m_sbyte = '0; m_sidx = 0;
        m_rx_acc = '0; m_rx_n = 0; m_ovr = 0; m_abort = 0;
    endtask

    task automatic model_pulse(output bit a);
        m_k++;
        if (m_k <= 2) a = 1'b1;
        else if (m_k == 3) a = (rx_q.size() < DEP);
        else if (m_k == 4) a = (tx_q.size() != 0);
        else if (!m_sending) begin
            if (m_prev_ack) begin
                m_sbyte = tx_q.pop_front();
                m_sidx = 7;
                m_sending = 1;
                a = m_sbyte[7];
            end else begin
                a = (tx_q.size() != 0);
            end
        end else if (m_sidx == 0) begin
            m_sending = 0;
            a = (tx_q.size() != 0);
        end else begin
            m_sidx--;
            a = m_sbyte[m_sidx];
        end
        m_prev_ack = a;
    endtask

    task automatic model_gap();
        if (m_k == 1 || m_k == 2) begin
            m_rx_acc = {m_rx_acc[6:0], (m_k == 1)};
            m_rx_n++;
            if (m_rx_n == 8) begin
                if (rx_q.size() < DEP) rx_q.push_back(m_rx_acc);
                else m_ovr = 1;
                m_rx_n = 0;
            end
        end else if (m_k == 3) begin
            m_rx_n = 0;
        end else if (m_k >= 5 && m_sending && m_sidx != 0) begin
            m_abort = 1;
        end
        m_k = 0; m_sending = 0; m_prev_ack = 0;
    endtask

    task automatic do_pulse(input string tag);
        bit exp_ack;
        model_pulse(exp_ack);
        testreq = 1'b1;
        repeat (7) @(negedge refclk);
        checks++;
        if (testack !== exp_ack) begin
            errors++;
            $display("FAIL %s pulse%0d testack got %b exp %b", tag, m_k, testack, exp_ack);
        end
        checks++;
        if (link_busy !== 1'b1) begin
            errors++;
            $display("FAIL %s pulse%0d link_busy got %b exp 1", tag, m_k, link_busy);
        end
        testreq = 1'b0;
        repeat (6) @(negedge refclk);
    endtask

    task automatic do_gap(input string tag);
        repeat (GAP + 8) @(negedge refclk);
        model_gap();
        checks++;
        if (link_busy !== 1'b0 || rx_overrun !== m_ovr || tx_abort !== m_abort ||
            rx_valid !== (rx_q.size() != 0)) begin
            errors++;
            $display("FAIL %s gap busy/ovr/abort/rxv got %b%b%b%b exp 0%b%b%b", tag,
                     link_busy, rx_overrun, tx_abort, rx_valid,
                     m_ovr, m_abort, (rx_q.size() != 0));
        end
        $display("gap %s: rx_q=%0d tx_q=%0d ovr=%0b abort=%0b", tag, rx_q.size(),
                 tx_q.size(), m_ovr, m_abort);
    endtask

    task automatic send_group(input int n, input string tag);
        for (int i = 0; i < n; i++) do_pulse(tag);
        do_gap(tag);
    endtask

    task automatic send_byte(input logic [7:0] b, input string tag);
        for (int i = 7; i >= 0; i--) send_group(b[i] ? 1 : 2, tag);
    endtask

    task automatic push_tx(input logic [7:0] b, input string tag);
        bit exp_rdy;
        exp_rdy = (tx_q.size() < DEP);
        checks++;
        if (tx_ready !== exp_rdy) begin
            errors++;
            $display("FAIL %s tx_ready got %b exp %b", tag, tx_ready, exp_rdy);
        end
        tx_data = b;
        tx_valid = 1'b1;
        @(negedge refclk);
        tx_valid = 1'b0;
        if (exp_rdy) tx_q.push_back(b);
        $display("push %s: %02h accepted=%0b", tag, b, exp_rdy);
    endtask

    task automatic drain_rx(input string tag);
        for (int i = 0; i <= DEP; i++) begin
            checks++;
            if (rx_valid !== (rx_q.size() != 0)) begin
                errors++;
                $display("FAIL %s rx_valid got %b exp %b", tag, rx_valid, (rx_q.size() != 0));
            end
            if (rx_q.size() == 0) break;
            checks++;
            if (rx_data !== rx_q[0]) begin
                errors++;
                $display("FAIL %s rx_data got %02h exp %02h", tag, rx_data, rx_q[0]);
            end
            $display("pop %s: %02h", tag, rx_q[0]);
            rx_ready = 1'b1;
            @(negedge refclk);
            rx_ready = 1'b0;
            void'(rx_q.pop_front());
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge refclk);
        rst_n = 1'b1;
        model_reset();
        @(negedge refclk);
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (testack !== 1'b0 || rx_valid !== 1'b0 || tx_ready !== 1'b1 ||
            rx_overrun !== 1'b0 || tx_abort !== 1'b0 || link_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset ack/rxv/txr/ovr/abt/busy got %b%b%b%b%b%b exp 001000",
                     testack, rx_valid, tx_ready, rx_overrun, tx_abort, link_busy);
        end
        repeat (GAP + 8) @(negedge refclk);
    endtask

    task automatic test_rx_byte();
        send_group(3, "poll");
        send_byte(8'hA5, "rxA5");
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'hA5) begin
            errors++;
            $display("FAIL rxA5 rx_valid/rx_data got %b/%02h exp 1/a5", rx_valid, rx_data);
        end
        drain_rx("rxA5");
    endtask

    task automatic test_tx_byte();
        push_tx(8'h3C, "tx3C");
        for (int i = 0; i < 13; i++) do_pulse("tx3C");
        do_gap("tx3C");
    endtask

    task automatic test_tx_empty_poll();
        for (int i = 0; i < 7; i++) do_pulse("txempty");
        push_tx(8'h81, "txempty");
        for (int i = 0; i < 10; i++) do_pulse("txempty");
        do_gap("txempty");
    endtask

    task automatic test_rx_overrun();
        for (int i = 0; i < DEP; i++) send_byte(8'($urandom), "rxfill");
        send_group(3, "rxfull_poll");
        send_byte(8'h5E, "rxover");
        checks++;
        if (rx_overrun !== 1'b1) begin
            errors++;
            $display("FAIL rxover rx_overrun got %b exp 1", rx_overrun);
        end
        drain_rx("rxover");
    endtask

    task automatic test_tx_abort();
        push_tx(8'hFF, "abort");
        push_tx(8'h96, "abort");
        for (int i = 0; i < 7; i++) do_pulse("abort");
        do_gap("abort");
        checks++;
        if (tx_abort !== 1'b1 || link_busy !== 1'b0) begin
            errors++;
            $display("FAIL abort tx_abort/link_busy got %b/%b exp 1/0", tx_abort, link_busy);
        end
        for (int i = 0; i < 13; i++) do_pulse("abort_next");
        do_gap("abort_next");
    endtask

    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 2) push_tx(8'($urandom), "rnd");
            else if (r == 2) drain_rx("rnd");
            else send_group($urandom_range(1, 14), "rnd");
        end
        drain_rx("rnd_end");
    endtask

    task automatic test_reset_midsend();
        send_byte(8'hC3, "rstmid");
        push_tx(8'h5A, "rstmid");
        for (int i = 0; i < 6; i++) do_pulse("rstmid");
        testreq = 1'b1;
        repeat (5) @(negedge refclk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (testack !== 1'b0 || tx_ready !== 1'b1 || rx_valid !== 1'b0 ||
            link_busy !== 1'b0 || rx_overrun !== 1'b0 || tx_abort !== 1'b0) begin
            errors++;
            $display("FAIL rstmid ack/txr/rxv/busy/ovr/abt got %b%b%b%b%b%b exp 010000",
                     testack, tx_ready, rx_valid, link_busy, rx_overrun, tx_abort);
        end
        testreq = 1'b0;
        repeat (3) @(negedge refclk);
        rst_n = 1'b1;
        model_reset();
        repeat (GAP + 8) @(negedge refclk);
        send_group(3, "post_rst");
    endtask

    initial begin
        rst_n = 1'b0;
        testreq = 1'b0;
        rx_ready = 1'b0;
        tx_data = '0;
        tx_valid = 1'b0;
        model_reset();
        test_reset();
        test_rx_byte();
        test_tx_byte();
        test_tx_empty_poll();
        test_rx_overrun();
        test_tx_abort();
        test_random();
        test_reset_midsend();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
